mul_share_checker: RTL and testbench

//  Response-side companion to the masked-multiplier stimulus benches: consumes the

---
 rtl/mask_pkg.sv | 20 ++
 rtl/share_delay_line.sv | 28 ++
 rtl/mul_share_checker.sv | 140 ++++++++++++++
 tb/tb_mul_share_checker.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mask_pkg.sv
// Shared definitions for the masked-multiplier harness: share count, checker FSM
// states and share recombination. The stimulus side reuses these too.
package mask_pkg;

   localparam int SHARES_DEF = 4;
   localparam int MAX_SHARES = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   // Callers zero-extend narrower share vectors; the extra zeros do not change the XOR.
   function automatic logic xor_reduce_shares(input logic [MAX_SHARES-1:0] i_sh);
      return ^i_sh;
   endfunction

endpackage

// File: rtl/share_delay_line.sv
// Fixed-depth shift register that carries {valid, expected} alongside the gadget
// pipeline so each expectation surfaces in the same cycle as its z shares.
module share_delay_line #(
   parameter int DEPTH = 1,
   parameter int WIDTH = 2
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   logic [DEPTH-1:0][WIDTH-1:0] r_pipe;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_pipe <= '0;
      end else begin
         r_pipe[0] <= i_d;
         for (int i = 1; i < DEPTH; i++) begin
            r_pipe[i] <= r_pipe[i-1];
         end
      end
   end

   assign o_q = r_pipe[DEPTH-1];

endmodule

// File: rtl/mul_share_checker.sv
// Response checker for a Boolean-masked AND gadget: recombines input and output
// shares, aligns the expected product to the gadget latency and scores each result.
module mul_share_checker
   import mask_pkg::*;
#(
   parameter int SHARES      = SHARES_DEF,
   parameter int LATENCY     = 1,
   parameter int NUM_SAMPLES = 16,
   parameter int CNT_W       = 16
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_start,
   input  logic              i_in_valid,
   input  logic [SHARES-1:0] i_x_sh,
   input  logic [SHARES-1:0] i_y_sh,
   input  logic [SHARES-1:0] i_z_sh,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_pass,
   output logic              o_chk_valid,
   output logic              o_chk_ok,
   output logic              o_z_plain,
   output logic [CNT_W-1:0]  o_err_cnt,
   output logic [CNT_W-1:0]  o_chk_cnt,
   output logic [CNT_W-1:0]  o_first_err_idx
);

   localparam logic [CNT_W-1:0] N_SMP = CNT_W'(NUM_SAMPLES);
   localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] ALL1  = '1;

   state_t           r_state;
   state_t           w_state_nxt;
   logic             w_enter_run;
   logic [CNT_W-1:0] r_issued;
   logic [CNT_W-1:0] r_chk_cnt;
   logic [CNT_W-1:0] r_err_cnt;
   logic [CNT_W-1:0] r_first_err_idx;
   logic             r_chk_valid;
   logic             r_chk_ok;

   logic             w_x_plain;
   logic             w_y_plain;
   logic             w_z_plain;
   logic             w_push;
   logic [1:0]       w_dl_d;
   logic [1:0]       w_dl_q;
   logic             w_tail_vld;
   logic             w_match;

   assign w_x_plain = xor_reduce_shares(MAX_SHARES'(i_x_sh));
   assign w_y_plain = xor_reduce_shares(MAX_SHARES'(i_y_sh));
   assign w_z_plain = xor_reduce_shares(MAX_SHARES'(i_z_sh));

   // Only RUN with budget left issues; everything else shifts a bubble in.
   assign w_push = (r_state == RUN) && i_in_valid && (r_issued < N_SMP);
   assign w_dl_d = {w_push, w_x_plain & w_y_plain};

   share_delay_line #(
      .DEPTH (LATENCY),
      .WIDTH (2)
   ) u_dly (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_d   (w_dl_d),
      .o_q   (w_dl_q)
   );

   assign w_tail_vld = w_dl_q[1];
   assign w_match    = (w_dl_q[0] == w_z_plain);

   always_comb begin
      w_state_nxt = r_state;
      w_enter_run = 1'b0;
      case (r_state)
         IDLE: begin
            if (i_start) begin
               w_state_nxt = RUN;
               w_enter_run = 1'b1;
            end
         end
         RUN: begin
            if (r_issued == N_SMP) w_state_nxt = DRAIN;
         end
         DRAIN: begin
            if (r_chk_cnt == N_SMP) w_state_nxt = DONE;
         end
         DONE: begin
            if (i_start) begin
               w_state_nxt = RUN;
               w_enter_run = 1'b1;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state     <= IDLE;
         r_chk_valid <= 1'b0;
         r_chk_ok    <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_chk_valid <= w_tail_vld;
         r_chk_ok    <= w_tail_vld && w_match;
      end
   end

   // Run start clears the scoreboard; the delay line is already empty by then.
   always_ff @(posedge i_clk) begin
      if (i_rst || w_enter_run) begin
         r_issued        <= '0;
         r_chk_cnt       <= '0;
         r_err_cnt       <= '0;
         r_first_err_idx <= ALL1;
      end else begin
         if (w_push) r_issued <= r_issued + ONE;
         if (w_tail_vld) begin
            r_chk_cnt <= r_chk_cnt + ONE;
            if (!w_match) begin
               if (r_err_cnt == '0)  r_first_err_idx <= r_chk_cnt;
               if (r_err_cnt != ALL1) r_err_cnt      <= r_err_cnt + ONE;
            end
         end
      end
   end

   assign o_busy          = (r_state == RUN) || (r_state == DRAIN);
   assign o_done          = (r_state == DONE);
   assign o_pass          = o_done && (r_err_cnt == '0);
   assign o_chk_valid     = r_chk_valid;
   assign o_chk_ok        = r_chk_ok;
   assign o_z_plain       = w_z_plain;
   assign o_err_cnt       = r_err_cnt;
   assign o_chk_cnt       = r_chk_cnt;
   assign o_first_err_idx = r_first_err_idx;

endmodule

// File: tb/tb_mul_share_checker.sv
// Bench for mul_share_checker: three instances (latency 1, 3, 8) beside an ideal
// registered-AND gadget, scored every cycle against an event-queue reference.
module tb_mul_share_checker;

   localparam int LAT [3] = '{1, 3, 8};
   localparam int NS      = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [2:0]  start_v = '0;
   logic        in_valid = 1'b0;
   logic        flip = 1'b0;
   logic [3:0]  x_sh = '0;
   logic [3:0]  y_sh = '0;
   logic [3:0]  zz [3];
   logic        zexp [3];
   logic [2:0]  busy, done, pass, cv, cok, zp;
   logic [15:0] cc [3];
   logic [15:0] ec [3];
   logic [15:0] fe [3];

   int  cyc = 0;
   bit  hist_p [0:8];
   bit  hist_f [0:8];
   logic [2:0] zmask = '0;

   int  total = 0;
   int  bad = 0;
   bit  armed = 0;

   // reference state: per instance, plus a ring of scheduled strobes keyed by edge
   bit  m_started [3];
   bit  m_done [3];
   int  m_issued [3];
   int  m_chk [3];
   int  m_err [3];
   int  m_first [3];
   int  m_done_at [3];
   bit  m_cv [3];
   bit  m_cok [3];
   bit  rv [3][64];
   bit  rok [3][64];

   always #5 clk = ~clk;

   function automatic logic [3:0] mk_z(input bit p, input bit f, input logic [2:0] m);
      logic [3:0] z;
      z[2:0] = m;
      z[3]   = (^m) ^ p;
      z[2]   = z[2] ^ f;
      return z;
   endfunction

   // ideal gadget: product of the shares sampled at each edge, freshly remasked
   always @(posedge clk) begin
      cyc <= cyc + 1;
      for (int i = 8; i > 0; i--) begin
         hist_p[i] <= hist_p[i-1];
         hist_f[i] <= hist_f[i-1];
      end
      hist_p[0] <= (^x_sh) & (^y_sh);
      hist_f[0] <= flip;
      zmask     <= 3'($urandom);
   end

   for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int L = LAT[g];
      assign zz[g]   = mk_z(hist_p[L-1], hist_f[L-1], zmask);
      assign zexp[g] = hist_p[L-1] ^ hist_f[L-1];
      mul_share_checker #(
         .SHARES      (4),
         .LATENCY     (L),
         .NUM_SAMPLES (NS),
         .CNT_W       (16)
      ) u_dut (
         .i_clk           (clk),
         .i_rst           (rst),
         .i_start         (start_v[g]),
         .i_in_valid      (in_valid),
         .i_x_sh          (x_sh),
         .i_y_sh          (y_sh),
         .i_z_sh          (zz[g]),
         .o_busy          (busy[g]),
         .o_done          (done[g]),
         .o_pass          (pass[g]),
         .o_chk_valid     (cv[g]),
         .o_chk_ok        (cok[g]),
         .o_z_plain       (zp[g]),
         .o_err_cnt       (ec[g]),
         .o_chk_cnt       (cc[g]),
         .o_first_err_idx (fe[g])
      );
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_dut(input int k);
      chk($sformatf("busy[%0d]", k),    32'(busy[k]), 32'(m_started[k] && !m_done[k]));
      chk($sformatf("done[%0d]", k),    32'(done[k]), 32'(m_done[k]));
      chk($sformatf("pass[%0d]", k),    32'(pass[k]), 32'(m_done[k] && m_err[k] == 0));
      chk($sformatf("chk_valid[%0d]", k), 32'(cv[k]), 32'(m_cv[k]));
      chk($sformatf("chk_ok[%0d]", k),  32'(cok[k]), 32'(m_cok[k]));
      chk($sformatf("chk_cnt[%0d]", k), 32'(cc[k]),  32'(m_chk[k]));
      chk($sformatf("err_cnt[%0d]", k), 32'(ec[k]),  32'(m_err[k]));
      chk($sformatf("first_err[%0d]", k), 32'(fe[k]), 32'(m_first[k]));
      chk($sformatf("z_plain[%0d]", k), 32'(zp[k]),  32'(zexp[k]));
   endtask

   // What instance k should look like after edge e, given the inputs sampled there.
   task automatic model_edge(input int k, input bit r, input bit st, input bit iv,
                             input bit fl, input int e);
      bit busy_pre;
      int slot;
      m_cv[k]  = 0;
      m_cok[k] = 0;
      if (r) begin
         m_started[k] = 0; m_done[k] = 0; m_issued[k] = 0; m_chk[k] = 0;
         m_err[k] = 0; m_first[k] = 'hFFFF; m_done_at[k] = -1;
         for (int i = 0; i < 64; i++) rv[k][i] = 0;
         return;
      end
      busy_pre = m_started[k] && !m_done[k];
      if (st && !busy_pre) begin
         m_started[k] = 1; m_done[k] = 0; m_issued[k] = 0; m_chk[k] = 0;
         m_err[k] = 0; m_first[k] = 'hFFFF; m_done_at[k] = -1;
      end else if (busy_pre && iv && m_issued[k] < NS) begin
         m_issued[k]++;
         slot = (e + LAT[k]) % 64;
         rv[k][slot]  = 1;
         rok[k][slot] = !fl;
         if (m_issued[k] == NS) m_done_at[k] = e + LAT[k] + 1;
      end
      slot = e % 64;
      if (rv[k][slot]) begin
         rv[k][slot] = 0;
         m_cv[k]  = 1;
         m_cok[k] = rok[k][slot];
         if (!rok[k][slot]) begin
            if (m_err[k] == 0) m_first[k] = m_chk[k];
            if (m_err[k] != 'hFFFF) m_err[k]++;
         end
         m_chk[k]++;
      end
      if (m_done_at[k] == e) m_done[k] = 1;
   endtask

   task automatic step(input bit r, input bit [2:0] st, input bit iv, input bit fl);
      int e;
      @(negedge clk);
      if (armed) for (int k = 0; k < 3; k++) check_dut(k);
      rst      = r;
      start_v  = st;
      in_valid = iv;
      flip     = fl;
      x_sh     = 4'($urandom);
      y_sh     = 4'($urandom);
      e = cyc + 1;
      for (int k = 0; k < 3; k++) model_edge(k, r, st[k], iv, fl, e);
      if (r) armed = 1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 3'b000, 0, 0);
   endtask

   initial begin
      // reset
      step(1, 3'b000, 0, 0);
      step(1, 3'b000, 1, 0);
      step(0, 3'b000, 1, 0);
      chk("rst_first_err", 32'(fe[0]), 32'hFFFF);
      chk("rst_busy", 32'(busy[0]), 32'd0);

      // all-good back-to-back run
      step(0, 3'b001, 0, 0);
      for (int i = 0; i < NS; i++) step(0, 3'b000, 1, 0);
      idle(6);
      chk("t1_chk_cnt", 32'(cc[0]), 32'd16);
      chk("t1_err_cnt", 32'(ec[0]), 32'd0);
      chk("t1_pass", 32'(pass[0]), 32'd1);
      chk("t1_first_err", 32'(fe[0]), 32'hFFFF);

      // fault inject on samples 3 and 9
      step(0, 3'b001, 0, 0);
      for (int i = 0; i < NS; i++) step(0, 3'b000, 1, (i == 3) || (i == 9));
      idle(6);
      chk("t2_err_cnt", 32'(ec[0]), 32'd2);
      chk("t2_first_err", 32'(fe[0]), 32'd3);
      chk("t2_pass", 32'(pass[0]), 32'd0);

      // restart from DONE clears; start mid-run ignored
      step(0, 3'b001, 0, 0);
      step(0, 3'b000, 1, 0);
      chk("t6_err_clr", 32'(ec[0]), 32'd0);
      chk("t6_chk_clr", 32'(cc[0]), 32'd0);
      chk("t6_busy", 32'(busy[0]), 32'd1);
      for (int i = 0; i < 4; i++) step(0, 3'b000, 1, 0);
      step(0, 3'b001, 1, 0);
      for (int i = 0; i < 10; i++) step(0, 3'b000, 1, 0);
      idle(6);
      chk("t6_chk_cnt", 32'(cc[0]), 32'd16);
      chk("t6_pass", 32'(pass[0]), 32'd1);

      // overrun: 20 pulses, 16 accepted
      step(0, 3'b001, 0, 0);
      for (int i = 0; i < 20; i++) step(0, 3'b000, 1, 0);
      idle(6);
      chk("t4_chk_cnt", 32'(cc[0]), 32'd16);
      chk("t4_pass", 32'(pass[0]), 32'd1);

      // reset mid-run at chk_cnt=5, then a clean run
      step(0, 3'b001, 0, 0);
      for (int i = 0; i < 30 && m_chk[0] < 5; i++) step(0, 3'b000, 1, 0);
      chk("t5_reached5", 32'(m_chk[0]), 32'd5);
      step(1, 3'b000, 1, 0);
      step(0, 3'b000, 0, 0);
      chk("t5_chk_rst", 32'(cc[0]), 32'd0);
      chk("t5_busy_rst", 32'(busy[0]), 32'd0);
      chk("t5_first_rst", 32'(fe[0]), 32'hFFFF);
      step(0, 3'b001, 0, 0);
      for (int i = 0; i < NS; i++) step(0, 3'b000, 1, 0);
      idle(6);
      chk("t5_pass", 32'(pass[0]), 32'd1);

      // latency sweep, 50% random duty
      step(0, 3'b111, 0, 0);
      for (int i = 0; i < 200 && (m_issued[0] < NS || m_issued[1] < NS || m_issued[2] < NS); i++)
         step(0, 3'b000, 1'($urandom_range(0, 1)), 0);
      idle(14);
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("t3_chk_cnt[%0d]", k), 32'(cc[k]), 32'd16);
         chk($sformatf("t3_pass[%0d]", k), 32'(pass[k]), 32'd1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
